// File: rtl/mb_pkg.sv
// mb_pkg -- shared definitions for the macroblock buffer.
//   MB_WORDS   : 32-bit words per 16x16 macroblock (16 rows x 4 words).
//   wr_state_t : write-side FSM states.
//   rd_state_t : read-side FSM states.
//   blk_pos()  : maps an H.264 4x4 luma block index to its sub-block
//                row/column inside the macroblock.
package mb_pkg;

   localparam int MB_WORDS = 64;

   typedef enum logic [0:0] {W_FILL, W_STALL} wr_state_t;
   typedef enum logic [0:0] {R_IDLE, R_EMIT}  rd_state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } blk_pos_t;

   // H.264 luma order walks 8x8 quadrants first, then 4x4s inside each:
   // the even index bits select the column, the odd bits the row.
   function automatic blk_pos_t blk_pos(input logic [3:0] k);
      blk_pos_t p;
      p.col = {k[2], k[0]};
      p.row = {k[3], k[1]};
      return p;
   endfunction

endpackage

// File: rtl/mb_bank.sv
// mb_bank -- one 64 x 32-bit macroblock bank.
//   clk   : clock
//   we    : write enable
//   waddr : word index, (row mod 16)*4 + word-in-row
//   wdata : 4 pixels, byte c = pixel c of the word
//   row   : 4x4 sub-block row (0..3)
//   col   : 4x4 sub-block column (0..3)
//   rdata : the 4 words of the addressed 4x4 block, word r in [r*32 +: 32]
// Storage is deliberately not reset; a bank is only read after 64 fresh
// writes have landed in it.
module mb_bank
   import mb_pkg::*;
(
   input  logic         clk,
   input  logic         we,
   input  logic [5:0]   waddr,
   input  logic [31:0]  wdata,
   input  logic [1:0]   row,
   input  logic [1:0]   col,
   output logic [127:0] rdata
);

   logic [31:0] mem [MB_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Block row r lives at word (4*row + r)*4 + col.
   always_comb begin
      rdata = '0;
      for (int r = 0; r < 4; r++) begin
         rdata[r*32 +: 32] = mem[{row, 2'(r), col}];
      end
   end

endmodule

// File: rtl/mb_buffer.sv
// mb_buffer -- gathers 4-pixel memory words into two ping-pong
// macroblock banks and emits each full macroblock as sixteen 4x4 blocks
// in H.264 luma order.
//   clk, rst_n       : clock, synchronous active-low reset
//   addr_valid/ready : upstream coordinate handshake (x, y, stop)
//   mem_addr         : word address (y*IMGWIDTH + x)/4, combinational
//   mem_rdata        : memory word, one cycle after mem_addr
//   blk_valid/ready  : downstream block handshake
//   blk_data         : pixel (r,c) at [(4r+c)*8 +: 8]
//   blk_idx          : 4x4 block index within the macroblock
//   mb_x, mb_y       : macroblock coordinates
//   blk_last         : last block of the frame's final macroblock
//   wr_state, rd_state : FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid && ready;
// the source holds its payload stable while valid && !ready, and ready
// never depends on valid.
module mb_buffer
   import mb_pkg::*;
#(
   parameter int IMGWIDTH  = 48,
   parameter int IMGHEIGHT = 48,
   parameter int MEM_AW    = 10
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              addr_valid,
   input  logic [31:0]       x,
   input  logic [31:0]       y,
   input  logic              stop,
   output logic              addr_ready,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic [127:0]      blk_data,
   output logic [3:0]        blk_idx,
   output logic [7:0]        mb_x,
   output logic [7:0]        mb_y,
   output logic              blk_last,
   output wr_state_t         wr_state,
   output rd_state_t         rd_state
);

   logic [31:0]     lin;
   logic            acc;
   logic            wr_pend;
   logic [5:0]      wr_idx;
   logic [7:0]      pend_mbx;
   logic [7:0]      pend_mby;
   logic            pend_last;
   logic            wr_ptr;
   logic            rd_ptr;
   logic [5:0]      wr_cnt;
   logic [1:0]      full;
   logic [1:0]      full_nxt;
   logic [1:0][7:0] tag_mbx;
   logic [1:0][7:0] tag_mby;
   logic [1:0]      tag_last;
   logic            completing;
   logic            target;
   logic            blk_hs;
   logic            blk_done;
   blk_pos_t        pos;
   logic [127:0]    bank_rd [2];
   wr_state_t       wr_state_nxt;
   rd_state_t       rd_state_nxt;

   assign lin      = y * 32'(IMGWIDTH) + x;
   assign mem_addr = lin[MEM_AW+1:2];

   // The write in flight this cycle finishes its bank, so the next
   // accepted word will land in the other bank.
   assign completing = wr_pend && (wr_cnt == 6'(MB_WORDS - 1));
   assign target     = completing ? ~wr_ptr : wr_ptr;
   assign addr_ready = rst_n && (wr_state == W_FILL) && !full[target];
   assign acc        = addr_valid && addr_ready;

   assign blk_valid = rst_n && (rd_state == R_EMIT);
   assign blk_hs    = blk_valid && blk_ready;
   assign blk_done  = blk_hs && (blk_idx == 4'd15);
   assign blk_last  = blk_valid && (blk_idx == 4'd15) && tag_last[rd_ptr];
   assign blk_data  = bank_rd[rd_ptr];
   assign mb_x      = tag_mbx[rd_ptr];
   assign mb_y      = tag_mby[rd_ptr];
   assign pos       = blk_pos(blk_idx);

   always_comb begin
      // A set (write side) and a clear (read side) always hit different
      // banks: a bank being written is never full.
      full_nxt = full;
      if (completing) full_nxt[wr_ptr] = 1'b1;
      if (blk_done)   full_nxt[rd_ptr] = 1'b0;

      wr_state_nxt = wr_state;
      case (wr_state)
         W_FILL:  if (completing && full[~wr_ptr]) wr_state_nxt = W_STALL;
         W_STALL: if (!full[wr_ptr])               wr_state_nxt = W_FILL;
         default: wr_state_nxt = W_FILL;
      endcase

      // Looking at full_nxt lets blk_valid rise the cycle right after the
      // 64th word is written.
      rd_state_nxt = rd_state;
      case (rd_state)
         R_IDLE:  if (full_nxt[rd_ptr]) rd_state_nxt = R_EMIT;
         R_EMIT:  if (blk_done)
                     rd_state_nxt = full_nxt[~rd_ptr] ? R_EMIT : R_IDLE;
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state  <= W_FILL;
         rd_state  <= R_IDLE;
         wr_pend   <= 1'b0;
         wr_idx    <= '0;
         pend_mbx  <= '0;
         pend_mby  <= '0;
         pend_last <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         wr_cnt    <= '0;
         full      <= '0;
         blk_idx   <= '0;
         tag_mbx   <= '0;
         tag_mby   <= '0;
         tag_last  <= '0;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
         full     <= full_nxt;
         wr_pend  <= acc;
         if (acc) begin
            wr_idx    <= {y[3:0], x[3:2]};
            pend_mbx  <= x[11:4];
            pend_mby  <= y[11:4];
            pend_last <= stop;
         end
         if (wr_pend) begin
            wr_cnt           <= completing ? 6'd0 : wr_cnt + 6'd1;
            tag_mbx[wr_ptr]  <= pend_mbx;
            tag_mby[wr_ptr]  <= pend_mby;
            tag_last[wr_ptr] <= (wr_cnt == 6'd0) ? pend_last
                                                 : (tag_last[wr_ptr] | pend_last);
            if (completing) wr_ptr <= ~wr_ptr;
         end
         if (blk_hs) begin
            blk_idx <= blk_idx + 4'd1;
            if (blk_done) rd_ptr <= ~rd_ptr;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      mb_bank u_bank (
         .clk   (clk),
         .we    (wr_pend && (wr_ptr == 1'(b))),
         .waddr (wr_idx),
         .wdata (mem_rdata),
         .row   (pos.row),
         .col   (pos.col),
         .rdata (bank_rd[b])
      );
   end

   logic unused_bits;
   assign unused_bits = ^{x[31:12], x[1:0], y[31:12], lin[31:MEM_AW+2],
                          lin[1:0], 32'(IMGHEIGHT)};

endmodule

// File: tb/tb_mb_buffer.sv
module tb_mb_buffer;
   import mb_pkg::*;

   localparam int W  = 48;
   localparam int H  = 48;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          addr_valid = 1'b0;
   logic [31:0]   x = '0;
   logic [31:0]   y = '0;
   logic          stop = 1'b0;
   logic          addr_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;
   logic          blk_valid;
   logic          blk_ready = 1'b0;
   logic [127:0]  blk_data;
   logic [3:0]    blk_idx;
   logic [7:0]    mb_x;
   logic [7:0]    mb_y;
   logic          blk_last;
   wr_state_t     wr_state;
   rd_state_t     rd_state;

   mb_buffer #(.IMGWIDTH(W), .IMGHEIGHT(H), .MEM_AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr_valid (addr_valid),
      .x          (x),
      .y          (y),
      .stop       (stop),
      .addr_ready (addr_ready),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .blk_data   (blk_data),
      .blk_idx    (blk_idx),
      .mb_x       (mb_x),
      .mb_y       (mb_y),
      .blk_last   (blk_last),
      .wr_state   (wr_state),
      .rd_state   (rd_state)
   );

   // ---------------- clock / memory model ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] mem [1024];
   always @(posedge clk) mem_rdata <= mem[mem_addr];

   bit rdy_rand  = 1'b0;
   bit rdy_level = 1'b0;
   always @(posedge clk) begin
      #2;
      blk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
   end

   // ---------------- counters / scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [148:0] exp_q[$];

   task automatic check(input string name, input logic [159:0] got,
                        input logic [159:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [7:0] pix(input int px, input int py, input int seed);
      return 8'(py * W + px + seed);
   endfunction

   task automatic load_mem(input int seed);
      for (int a = 0; a < 1024; a++) begin
         if (a < W * H / 4) begin
            int px;
            int py;
            px = (a * 4) % W;
            py = (a * 4) / W;
            mem[a] = {pix(px + 3, py, seed), pix(px + 2, py, seed),
                      pix(px + 1, py, seed), pix(px, py, seed)};
         end else begin
            mem[a] = '0;
         end
      end
   endtask

   // {last, mb_x, mb_y, idx, data}
   function automatic logic [148:0] exp_blk(input int mx, input int my,
                                            input int k, input bit last,
                                            input int seed);
      logic [127:0] d;
      int col;
      int row;
      col = ((k >> 2) & 1) * 2 + (k & 1);
      row = ((k >> 3) & 1) * 2 + ((k >> 1) & 1);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            d[(4*r+c)*8 +: 8] = pix(mx*16 + col*4 + c, my*16 + row*4 + r, seed);
      return {last, 8'(mx), 8'(my), 4'(k), d};
   endfunction

   // ---------------- monitor ----------------
   int acc_cnt, blocks_out, last_cnt;
   int hs15_cyc, acc64_cyc, first_valid_cyc, stall_acc, resume_cyc;
   bit hold_pend;
   logic [148:0] hold_snap;
   logic [148:0] act;
   logic [148:0] e;
   logic [127:0] blk2_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         acc_cnt = 0; blocks_out = 0; last_cnt = 0;
         hs15_cyc = -1; acc64_cyc = -1; first_valid_cyc = -1;
         stall_acc = -1; resume_cyc = -1; hold_pend = 1'b0;
      end else begin
         act = {blk_last, mb_x, mb_y, blk_idx, blk_data};
         if (hold_pend)
            check("stall_hold", {1'b0, blk_valid, act}, {1'b0, 1'b1, hold_snap});
         hold_pend = blk_valid && !blk_ready;
         hold_snap = act;
         if (blk_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            check("early_valid", 160'(acc_cnt >= 64 * (blocks_out / 16 + 1)), 160'(1));
         end
         if (blk_valid && blk_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_blk", 160'(act), 160'(0) - 1);
            end else begin
               e = exp_q.pop_front();
               check("blk_cmp", 160'(act), 160'(e));
            end
            if (blk_idx == 4'd15 && hs15_cyc < 0) hs15_cyc = cyc;
            if (blk_idx == 4'd2 && blocks_out < 16) blk2_data = blk_data;
            if (blk_last) last_cnt++;
            blocks_out++;
         end
         if (addr_valid) begin
            if (addr_ready) begin
               acc_cnt++;
               if (acc_cnt == 64) acc64_cyc = cyc;
               if (stall_acc >= 0 && resume_cyc < 0) resume_cyc = cyc;
            end else if (stall_acc < 0) begin
               stall_acc = acc_cnt;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   int gap_max = 0;
   bit drv_abort = 1'b0;

   task automatic send_word(input int px, input int py, input bit last);
      int n;
      bit r;
      if (gap_max > 0) begin
         addr_valid = 1'b0;
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
      addr_valid = 1'b1;
      x = 32'(px);
      y = 32'(py);
      stop = last;
      n = 0;
      while (1) begin
         @(negedge clk);
         r = addr_ready;
         @(posedge clk); #1;
         if (r) break;
         n++;
         if (n > 3000) begin
            check("addr_ready_timeout", 160'(0), 160'(1));
            drv_abort = 1'b1;
            break;
         end
      end
      addr_valid = 1'b0;
      stop = 1'b0;
   endtask

   task automatic send_mb(input int mx, input int my, input bit last,
                          input bit push, input int seed);
      if (push)
         for (int k = 0; k < 16; k++)
            exp_q.push_back(exp_blk(mx, my, k, last && (k == 15), seed));
      for (int r = 0; r < 16; r++)
         for (int w = 0; w < 4; w++)
            if (!drv_abort)
               send_word(mx*16 + w*4, my*16 + r, last && r == 15 && w == 3);
   endtask

   task automatic send_frame(input int seed);
      for (int my = 0; my < 3; my++)
         for (int mx = 0; mx < 3; mx++)
            send_mb(mx, my, (mx == 2) && (my == 2), 1'b1, seed);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); #1; n++; end
      check("drain", 160'(exp_q.size()), 160'(0));
      exp_q.delete();
      repeat (5) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [127:0] want2;
      rst_n = 1'b0;
      load_mem(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_addr_ready", 160'(addr_ready), 160'(0));
      check("rst_blk_valid",  160'(blk_valid),  160'(0));
      check("rst_blk_last",   160'(blk_last),   160'(0));
      check("rst_blk_idx",    160'(blk_idx),    160'(0));
      check("rst_mb_x",       160'(mb_x),       160'(0));
      check("rst_mb_y",       160'(mb_y),       160'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("addr_ready_after_rst", 160'(addr_ready), 160'(1));
      @(posedge clk); #1;

      // single macroblock: latency and block 2 placement
      rdy_level = 1'b1;
      send_mb(0, 0, 1'b1, 1'b1, 0);
      drain();
      check("valid_latency", 160'(first_valid_cyc), 160'(acc64_cyc + 2));
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            want2[(4*r+c)*8 +: 8] = pix(c, 4 + r, 0);
      check("blk2_pixels", 160'(blk2_data), 160'(want2));
      check("single_last_cnt", 160'(last_cnt), 160'(1));

      // full frame, always ready
      do_reset();
      load_mem(17);
      send_frame(17);
      drain();
      check("frame_blocks", 160'(blocks_out), 160'(144));
      check("frame_last_cnt", 160'(last_cnt), 160'(1));

      // downstream stalled for the first 200 cycles
      do_reset();
      load_mem(40);
      rdy_level = 1'b0;
      fork
         send_frame(40);
         begin
            repeat (200) begin @(posedge clk); #1; end
            rdy_level = 1'b1;
         end
      join
      drain();
      check("stall_after_words", 160'(stall_acc), 160'(128));
      check("resume_cycle", 160'(resume_cyc), 160'(hs15_cyc + 2));
      check("bp_blocks", 160'(blocks_out), 160'(144));

      // reset after a partial macroblock, then a clean frame
      do_reset();
      load_mem(99);
      for (int i = 0; i < 30; i++)
         send_word((i % 4) * 4, i / 4, 1'b0);
      do_reset();
      load_mem(5);
      send_frame(5);
      drain();
      check("rst_mid_blocks", 160'(blocks_out), 160'(144));
      check("rst_mid_last_cnt", 160'(last_cnt), 160'(1));

      // random gaps upstream, random ready downstream
      do_reset();
      load_mem(77);
      rdy_rand = 1'b1;
      gap_max = 2;
      send_frame(77);
      rdy_rand = 1'b0;
      rdy_level = 1'b1;
      gap_max = 0;
      drain();
      check("rand_blocks", 160'(blocks_out), 160'(144));
      check("rand_last_cnt", 160'(last_cnt), 160'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mb_buffer.md
MB_BUFFER -- requirements
Module: mb_buffer

Interface
REQ-001 Parameter IMGWIDTH, default 48, frame width in pixels (multiple of 16).
REQ-002 Parameter IMGHEIGHT, default 48, frame height in pixels (multiple of 16).
REQ-003 Parameter MEM_AW, default 10, frame-memory word-address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 addr_valid  input  1  upstream pixel-word coordinate valid.
REQ-007 x  input  32  upstream column of first pixel in a 4-pixel word (multiple of 4).
REQ-008 y  input  32  upstream pixel row.
REQ-009 stop  input  1  upstream flag: current coordinate is the last of the frame.
REQ-010 addr_ready  output  1  block accepts the coordinate this cycle.
REQ-011 mem_addr  output  MEM_AW  frame-memory word address, (y*IMGWIDTH + x)/4.
REQ-012 mem_rdata  input  32  memory word, valid exactly one cycle after mem_addr; byte c = pixel x+c.
REQ-013 blk_valid  output  1  4x4 block available.
REQ-014 blk_ready  input  1  downstream accepts block.
REQ-015 blk_data  output  128  pixel (row r, col c) at bits [(4r+c)*8 +: 8].
REQ-016 blk_idx  output  4  H.264 4x4 luma block index within macroblock.
REQ-017 mb_x, mb_y  output  8 each  macroblock coordinates (pixel/16).
REQ-018 blk_last  output  1  high with block 15 of the frame's final macroblock.

Function
REQ-019 Transfer on addr_valid && addr_ready; mem_addr driven combinationally from x,y that cycle.
REQ-020 Word accepted in cycle N is written in cycle N+1 into the write bank at index (y mod 16)*4 + (x mod 16)/4.
REQ-021 Two ping-pong banks of 64x32-bit words; per-bank full flag, mb_x/mb_y and last tag latched from the bank's first/any accepted word (last = stop seen).
REQ-022 Write side counts 64 writes per bank; on 64th write the bank's full flag sets and the write pointer toggles; arrival order within the macroblock is irrelevant.
REQ-023 Write FSM: W_FILL (addr_ready=1) -> W_STALL when the next bank is full and the current one is completing; W_STALL -> W_FILL the cycle after that bank's full flag clears.
REQ-024 addr_ready = 0 whenever the bank about to receive the next write is full or is the completing bank with a write pending.
REQ-025 Read FSM: R_IDLE -> R_EMIT when read bank full; emits blk_idx 0..15 in order, one per accepted handshake.
REQ-026 Block k uses sub-block column {k[2],k[0]} and row {k[3],k[1]}; rows are bank words at (4*row+r)*4+col, r=0..3.
REQ-027 blk_valid first high in cycle N+2 when the 64th word was accepted in cycle N.
REQ-028 blk_data/blk_idx/mb_x/mb_y stable while blk_valid && !blk_ready.
REQ-029 On handshake of blk_idx 15: read bank full flag clears, read pointer toggles, R_EMIT continues next cycle if the other bank is full, else R_IDLE.
REQ-030 Full-flag clear and set in the same cycle on different banks both take effect; throughput one word per cycle in and one block per cycle out sustained.
REQ-031 blk_last = blk_valid && blk_idx==15 && bank last tag.

Reset
REQ-032 rst_n low: addr_ready=0, blk_valid=0, blk_last=0, blk_idx=0, mb_x=mb_y=0, full flags, counters and pointers cleared, FSMs to W_FILL/R_IDLE.
REQ-033 Reset mid-operation discards in-flight memory read and partial banks; bank storage is not reset.
REQ-034 addr_ready rises the first cycle after rst_n returns high.

Structure
REQ-035 Shared package mb_pkg holds FSM state enums, MB_WORDS=64, block-index-to-position mapping function.
REQ-036 One sub-module mb_bank (64x32 storage, 1 write port, 4-word read port) instantiated twice.

Verification
REQ-037 Raster 48x48 frame, ramp pixels, blk_ready=1 -> 144 blocks, blk_idx 0..15 per MB, MB order (0,0),(1,0)..(2,2), data matches model, one blk_last.
REQ-038 blk_ready=0 for 200 cycles from start -> addr_ready low after exactly 128 accepted words, resumes one cycle after first bank drains.
REQ-039 Single MB, check blk_idx 2 returns pixels at columns 0..3 rows 4..7 and blk_valid latency 2 cycles after 64th word.
REQ-040 rst_n low after 30 words then full frame -> first MB output contains only post-reset data, blk_valid never high before 64 new words.
REQ-041 Random blk_ready and addr_valid toggling over full frame -> no lost/duplicate block, outputs stable under stall.
